pll_lock_monitor: RTL

//  Consumer end of the PLL: runs on the PLL output clock, synchronises the PLL lock flag,

---
 rtl/pll_lock_monitor_pkg.sv | 27 ++
 rtl/pll_lock_monitor_if.sv | 43 ++++
 rtl/pll_lock_monitor_sync_bit.sv | 32 +++
 rtl/pll_lock_monitor.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/pll_lock_monitor_pkg.sv
// -----------------------------------------------------------------------------
// pll_mon_pkg
// Purpose : shared types and constants for the PLL lock monitor.
//           - state_t       : monitor FSM states (2-bit encoding)
//           - LOSS_CNT_W    : width of the loss counter output
//           - LOSS_CNT_MAX  : saturation value of the loss counter
//           - cnt_width()   : counter width for a 0..n-1 count, never below 1 bit
// Ports   : none (package)
// -----------------------------------------------------------------------------
package pll_mon_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2,
      HOLDOFF   = 2'd3
   } state_t;

   localparam int              LOSS_CNT_W   = 8;
   localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'hFF;

   // $clog2(1) is 0, which would give a zero-width vector.
   function automatic int cnt_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pll_lock_monitor_if.sv
// -----------------------------------------------------------------------------
// pll_lock_monitor_if
// Purpose : groups the PLL lock monitor's functional signals.
// Signals :
//   locked_async  PLL lock flag, asynchronous to the monitor clock
//   clear_sticky  one-cycle pulse clearing lock_lost
//   sys_reset_n   registered active-low reset to core logic
//   ready         high while the monitor is in RUN
//   lock_lost     sticky loss-of-lock flag
//   loss_count    saturating loss counter
// Modports:
//   master : drives lock flag / clear pulse, observes status (PLL side / bench)
//   slave  : the monitor itself
// -----------------------------------------------------------------------------
interface pll_lock_monitor_if;
   import pll_mon_pkg::*;

   logic                  locked_async;
   logic                  clear_sticky;
   logic                  sys_reset_n;
   logic                  ready;
   logic                  lock_lost;
   logic [LOSS_CNT_W-1:0] loss_count;

   modport master (
      output locked_async,
      output clear_sticky,
      input  sys_reset_n,
      input  ready,
      input  lock_lost,
      input  loss_count
   );

   modport slave (
      input  locked_async,
      input  clear_sticky,
      output sys_reset_n,
      output ready,
      output lock_lost,
      output loss_count
   );

endinterface

// File: rtl/pll_lock_monitor_sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Purpose : plain flop-chain synchroniser for a single asynchronous bit.
//           q is d delayed through STAGES flops; all flops clear to 0 on reset.
// Ports   :
//   clock    in  1  destination clock
//   reset_n  in  1  synchronous active-low reset
//   d        in  1  asynchronous input
//   q        out 1  synchronised output
// -----------------------------------------------------------------------------
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_reg;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         chain_reg <= '0;
      end else begin
         chain_reg <= {chain_reg[STAGES-2:0], d};
      end
   end

   assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// -----------------------------------------------------------------------------
// pll_lock_monitor
// Purpose : runs on the PLL output clock. Synchronises the PLL lock flag, holds
//           the core in reset until lock has been stable for SETTLE_CYCLES,
//           filters lock drops shorter than GLITCH_CYCLES, and on a real loss
//           forces a HOLDOFF_CYCLES reset hold-off and sets a sticky flag.
// Optional: define PLL_LOSS_COUNT_EN to build the saturating loss counter;
//           without it loss_count is tied to 8'h00.
// Ports   :
//   clock    in  1  PLL output clock, sole clock domain
//   reset_n  in  1  synchronous active-low reset
//   bus      slave modport of pll_lock_monitor_if (locked_async, clear_sticky,
//            sys_reset_n, ready, lock_lost, loss_count)
// -----------------------------------------------------------------------------
module pll_lock_monitor
   import pll_mon_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int SETTLE_CYCLES  = 1024,
   parameter int GLITCH_CYCLES  = 4,
   parameter int HOLDOFF_CYCLES = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   pll_lock_monitor_if.slave  bus
);

   localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);
   localparam int GLITCH_W = cnt_width(GLITCH_CYCLES);
   localparam int HOLD_W   = cnt_width(HOLDOFF_CYCLES);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [GLITCH_W-1:0] GLITCH_LAST = GLITCH_W'(GLITCH_CYCLES - 1);
   localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLDOFF_CYCLES - 1);

   logic                locked_sync;
   state_t              state_reg;
   logic [SETTLE_W-1:0] settle_cnt_reg;
   logic [GLITCH_W-1:0] glitch_cnt_reg;
   logic [HOLD_W-1:0]   hold_cnt_reg;
   logic                run_reg;
   logic                lock_lost_reg;
   logic                loss_event;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (bus.locked_async),
      .q       (locked_sync)
   );

   // The edge on which RUN is left for HOLDOFF; feeds the sticky flag and counter.
   assign loss_event = (state_reg == RUN) && !locked_sync && (glitch_cnt_reg == GLITCH_LAST);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg      <= WAIT_LOCK;
         settle_cnt_reg <= '0;
         glitch_cnt_reg <= '0;
         hold_cnt_reg   <= '0;
         run_reg        <= 1'b0;
         lock_lost_reg  <= 1'b0;
      end else begin
         case (state_reg)
            WAIT_LOCK: begin
               if (locked_sync) begin
                  state_reg      <= SETTLE;
                  settle_cnt_reg <= '0;
               end
            end
            SETTLE: begin
               // Any drop while settling restarts acquisition, no filtering.
               if (!locked_sync) begin
                  state_reg <= WAIT_LOCK;
               end else if (settle_cnt_reg == SETTLE_LAST) begin
                  state_reg      <= RUN;
                  run_reg        <= 1'b1;
                  glitch_cnt_reg <= '0;
               end else begin
                  settle_cnt_reg <= settle_cnt_reg + 1'b1;
               end
            end
            RUN: begin
               if (locked_sync) begin
                  glitch_cnt_reg <= '0;
               end else if (glitch_cnt_reg == GLITCH_LAST) begin
                  state_reg      <= HOLDOFF;
                  hold_cnt_reg   <= '0;
                  glitch_cnt_reg <= '0;
                  run_reg        <= 1'b0;
               end else begin
                  glitch_cnt_reg <= glitch_cnt_reg + 1'b1;
               end
            end
            HOLDOFF: begin
               // Lock state is ignored here; the core stays in reset for the full window.
               if (hold_cnt_reg == HOLD_LAST) begin
                  state_reg <= WAIT_LOCK;
               end else begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= WAIT_LOCK;
               run_reg   <= 1'b0;
            end
         endcase

         // A loss on the same edge as a clear pulse keeps the flag set.
         if (loss_event) begin
            lock_lost_reg <= 1'b1;
         end else if (bus.clear_sticky) begin
            lock_lost_reg <= 1'b0;
         end
      end
   end

   assign bus.sys_reset_n = run_reg;
   assign bus.ready       = run_reg;
   assign bus.lock_lost   = lock_lost_reg;

`ifdef PLL_LOSS_COUNT_EN
   logic [LOSS_CNT_W-1:0] loss_count_reg;

   // Only reset_n clears the counter; clear_sticky has no effect on it.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         loss_count_reg <= '0;
      end else if (loss_event && (loss_count_reg != LOSS_CNT_MAX)) begin
         loss_count_reg <= loss_count_reg + 1'b1;
      end
   end

   assign bus.loss_count = loss_count_reg;
`else
   assign bus.loss_count = 8'h00;
`endif

endmodule
